// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word CPU requests into aligned,
// big-endian word accesses to a single-port memory. Sub-word stores use
// read-modify-write. Every wait on the memory is bounded by TIMEOUT.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request; latches it and checks for errors
// RD      | mem_read strobe cycle (loads and sub-word stores)
// RD_WAIT | waiting for mem_rd_done; extract the load or merge the store
// WR      | mem_write strobe cycle
// WR_WAIT | waiting for mem_wr_done
// RESP    | response is registered out on the following cycle
module load_store_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [31:0]           mem_wr_data,
    input  logic [31:0]           mem_rd_data,
    input  logic                  mem_rd_done,
    input  logic                  mem_wr_done
);

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t                state;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    // Only the low halfword is needed after accept: word stores are
    // written straight from the request in IDLE.
    logic [15:0]           wdata_q;
    logic [31:0]           data_q;
    logic                  err_q;
    logic [CW-1:0]         cnt;

    logic                  req_bad;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           load_val;
    logic [31:0]           merged;

    assign req_ready = (state == IDLE);

    // Illegal size or misaligned address for the incoming request.
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            2'b01:   req_bad = req_addr[0];
            2'b10:   req_bad = (req_addr[1:0] != 2'b00);
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
    end

    // Big-endian lane selection for loads and lane replacement for merges.
    always_comb begin
        byte_sel = 8'h00;
        load_val = mem_rd_data;
        merged   = mem_rd_data;
        case (addr_q[1:0])
            2'd0:    byte_sel = mem_rd_data[31:24];
            2'd1:    byte_sel = mem_rd_data[23:16];
            2'd2:    byte_sel = mem_rd_data[15:8];
            default: byte_sel = mem_rd_data[7:0];
        endcase
        half_sel = addr_q[1] ? mem_rd_data[15:0] : mem_rd_data[31:16];
        case (size_q)
            2'b00: begin
                load_val = signed_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
                case (addr_q[1:0])
                    2'd0:    merged[31:24] = wdata_q[7:0];
                    2'd1:    merged[23:16] = wdata_q[7:0];
                    2'd2:    merged[15:8]  = wdata_q[7:0];
                    default: merged[7:0]   = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                load_val = signed_q ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
                if (addr_q[1])
                    merged[15:0] = wdata_q;
                else
                    merged[31:16] = wdata_q;
            end
            default: ;
        endcase
    end

    // Sequencer with registered strobes and response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            size_q         <= 2'b00;
            signed_q       <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= 16'h0000;
            data_q         <= 32'h0;
            err_q          <= 1'b0;
            cnt            <= '0;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= 32'h0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_read_addr  <= '0;
            mem_write_addr <= '0;
            mem_wr_data    <= 32'h0;
        end else begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata[15:0];
                        data_q   <= 32'h0;
                        err_q    <= req_bad;
                        if (req_bad) begin
                            state <= RESP;
                        end else if (!req_we || req_size != 2'b10) begin
                            state         <= RD;
                            mem_read      <= 1'b1;
                            mem_read_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        end else begin
                            state          <= WR;
                            mem_write      <= 1'b1;
                            mem_write_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wr_data    <= req_wdata;
                        end
                    end
                end
                RD: begin
                    cnt   <= '0;
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (mem_rd_done) begin
                        if (!we_q) begin
                            data_q <= load_val;
                            state  <= RESP;
                        end else begin
                            state          <= WR;
                            mem_write      <= 1'b1;
                            mem_write_addr <= {addr_q[ADDR_WIDTH-1:2], 2'b00};
                            mem_wr_data    <= merged;
                        end
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR: begin
                    cnt   <= '0;
                    state <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (mem_wr_done) begin
                        state <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_err   <= err_q;
                    resp_rdata <= err_q ? 32'h0 : data_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written timeout and
// reset sequences, then random traffic against a byte-array reference memory.
module tb_load_store_unit;

    localparam int AW = 10;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_read_addr;
    logic [AW-1:0] mem_write_addr;
    logic [31:0]   mem_wr_data;
    logic [31:0]   mem_rd_data;
    logic          mem_rd_done;
    logic          mem_wr_done;

    load_store_unit #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .mem_rd_done(mem_rd_done), .mem_wr_done(mem_wr_done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 8) return 32'h80F12233;
        return (32'(i) * 32'h01030507) ^ 32'hA5C31E69;
    endfunction

    // Memory model: done one cycle after the strobe is sampled, unless stalled.
    logic [31:0] mem [0:255];
    bit          mem_loaded;
    bit          stall_rd = 1'b0;
    bit          stall_wr = 1'b0;
    int          n_reads = 0, n_writes = 0, n_resp = 0, n_overlap = 0, n_unaligned = 0;

    always @(posedge clk) begin
        mem_rd_done <= 1'b0;
        mem_wr_done <= 1'b0;
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end
        if (resp_valid) n_resp <= n_resp + 1;
        if (mem_read && mem_write) n_overlap <= n_overlap + 1;
        if ((mem_read && mem_read_addr[1:0] != 2'b00) || (mem_write && mem_write_addr[1:0] != 2'b00))
            n_unaligned <= n_unaligned + 1;
        if (mem_read) begin
            n_reads <= n_reads + 1;
            if (!stall_rd) begin
                mem_rd_done <= 1'b1;
                mem_rd_data <= mem[mem_read_addr[AW-1:2]];
            end
        end
        if (mem_write) begin
            n_writes <= n_writes + 1;
            if (!stall_wr) begin
                mem_wr_done <= 1'b1;
                mem[mem_write_addr[AW-1:2]] <= mem_wr_data;
            end
        end
    end

    // Reference: memory as a flat big-endian byte array.
    logic [7:0] ref_mem [0:1023];

    function automatic int size_bytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit ref_err(input logic [1:0] s, input int a);
        if (s == 2'b11) return 1'b1;
        return (a % size_bytes(s)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input int a, input int n, input bit sgn);
        longint v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[a + i]);
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic ref_store(input int a, input int n, input logic [31:0] wd);
        for (int i = 0; i < n; i++) ref_mem[a + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [AW-1:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int nrd, output int nwr);
        int r0, w0;
        @(negedge clk);
        r0 = n_reads;
        w0 = n_writes;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat   = -1;
        rdata = 32'h0;
        err   = 1'b0;
        for (int c = 1; c <= TO + 20; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
        nrd = n_reads - r0;
        nwr = n_writes - w0;
    endtask

    typedef struct {
        logic          we;
        logic [1:0]    size;
        logic          sgn;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic [31:0]   exp_rd;
        logic          exp_err;
        int            exp_lat;
        int            exp_nrd;
        int            exp_nwr;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          lat, nrd, nwr, r0, a, n;
        logic [31:0] rd, exp_rd;
        logic        er, we, sg;
        logic [1:0]  sz;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 4, 0, 1};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0, 4, 1, 0};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 10'h021, 32'h0,        32'hFFFFFFF1, 1'b0, 4, 1, 0};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 10'h022, 32'h0,        32'h00002233, 1'b0, 4, 1, 0};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 10'h023, 32'hAAAAAA55, 32'h00000000, 1'b0, 6, 1, 1};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 10'h020, 32'h0,        32'h80F12255, 1'b0, 4, 1, 0};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 10'h006, 32'h0,        32'h00000000, 1'b1, 2, 0, 0};
        vecs[7]  = '{1'b0, 2'b11, 1'b0, 10'h000, 32'h0,        32'h00000000, 1'b1, 2, 0, 0};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 10'h021, 32'h12345678, 32'h00000000, 1'b1, 2, 0, 0};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 10'h020, 32'h0,        32'hFFFF80F1, 1'b0, 4, 1, 0};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 10'h020, 32'h0,        32'h00000080, 1'b0, 4, 1, 0};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 10'h022, 32'h0,        32'h00000022, 1'b0, 4, 1, 0};
        vecs[12] = '{1'b1, 2'b01, 1'b0, 10'h020, 32'h1234ABCD, 32'h00000000, 1'b0, 6, 1, 1};
        vecs[13] = '{1'b0, 2'b10, 1'b1, 10'h020, 32'h0,        32'hABCD2255, 1'b0, 4, 1, 0};
        vecs[14] = '{1'b1, 2'b10, 1'b0, 10'h012, 32'hCAFEF00D, 32'h00000000, 1'b1, 2, 0, 0};

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'((init_word(i / 4) >> (8 * (3 - i % 4))) & 32'hFF);

        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = 32'h0;

        // Reset values while reset is asserted.
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst resp_valid", 32'(resp_valid), 32'h0);
        chk("rst resp_err", 32'(resp_err), 32'h0);
        chk("rst resp_rdata", resp_rdata, 32'h0);
        chk("rst mem_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst addrs", {12'h0, mem_read_addr, mem_write_addr}, 32'h0);
        chk("rst mem_wr_data", mem_wr_data, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst req_ready", 32'(req_ready), 32'h1);

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wd, lat, rd, er, nrd, nwr);
            if (vecs[i].we && !vecs[i].exp_err)
                ref_store(int'(vecs[i].addr), size_bytes(vecs[i].size), vecs[i].wd);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d reads", i), 32'(nrd), 32'(vecs[i].exp_nrd));
            chk($sformatf("vec%0d writes", i), 32'(nwr), 32'(vecs[i].exp_nwr));
        end
        chk("byte store merged word", mem[8], 32'hABCD2255);

        // Load with memory never answering: timeout error after TO wait cycles.
        stall_rd = 1'b1;
        do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, rd, er, nrd, nwr);
        stall_rd = 1'b0;
        chk("timeout err", 32'(er), 32'h1);
        chk("timeout rdata", rd, 32'h0);
        chk("timeout latency", 32'(lat), 32'(TO + 3));
        @(negedge clk);
        chk("timeout back idle", 32'(req_ready), 32'h1);

        // Reset while the word store waits in WR_WAIT.
        stall_wr = 1'b1;
        @(negedge clk);
        r0         = n_resp;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 10'h030;
        req_wdata  = 32'h13572468;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("midrst resp_valid", 32'(resp_valid), 32'h0);
        chk("midrst write addr", 32'(mem_write_addr), 32'h0);
        chk("midrst wr_data", mem_wr_data, 32'h0);
        @(negedge clk);
        rst      = 1'b1;
        stall_wr = 1'b0;
        @(negedge clk);
        chk("postrst strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("postrst req_ready", 32'(req_ready), 32'h1);
        chk("midrst no response", 32'(n_resp - r0), 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 10'h030, 32'h24681357, lat, rd, er, nrd, nwr);
        ref_store(32'h030, 4, 32'h24681357);
        chk("after rst err", 32'(er), 32'h0);
        chk("after rst latency", 32'(lat), 32'h4);

        // Random traffic against the byte-array reference.
        for (int t = 0; t < 50; t++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = int'($urandom_range(0, 63));
            exp_rd = 32'h0;
            do_req(we, sz, sg, AW'(a), $urandom, lat, rd, er, nrd, nwr);
            if (ref_err(sz, a)) begin
                chk($sformatf("rand%0d err", t), 32'(er), 32'h1);
                chk($sformatf("rand%0d latency", t), 32'(lat), 32'h2);
            end else begin
                n = size_bytes(sz);
                if (we) ref_store(a, n, req_wdata);
                else exp_rd = ref_load(a, n, sg);
                chk($sformatf("rand%0d err", t), 32'(er), 32'h0);
                chk($sformatf("rand%0d latency", t), 32'(lat), (we && n < 4) ? 32'h6 : 32'h4);
            end
            chk($sformatf("rand%0d rdata", t), rd, exp_rd);
        end

        @(negedge clk);
        for (int w = 0; w < 16; w++)
            chk($sformatf("final mem word %0d", w), mem[w],
                {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]});
        chk("read/write overlap", 32'(n_overlap), 32'h0);
        chk("unaligned strobe", 32'(n_unaligned), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
